// File: rtl/mem_access_pkg.sv
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared size encodings, FSM state type and alignment check
//               for the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_access_pkg;

  // Data word width; the lane logic assumes four byte lanes.
  localparam int WORD_W = 32;

  // Request size encodings (2'b11 is illegal).
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_ERR  = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  // True when the request cannot be served as a single aligned access.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    return (size == 2'b11) ||
           ((size == SZ_HALF) && addr_lo[0]) ||
           ((size == SZ_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_unit_lane_align.sv
// ============================================================================
// Module      : mem_lane_align
// Description : Combinational byte-lane steering. Extracts and extends a
//               load value from a memory word, and merges store data into
//               the lanes of a captured word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  input  logic [1:0]        addr_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] load_o,
  output logic [WORD_W-1:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection for loads and lane replacement for stores.
  always_comb begin
    byte_sel = word_i[{addr_i, 3'b000} +: 8];
    half_sel = word_i[{addr_i[1], 4'b0000} +: 16];
    load_o   = '0;
    merged_o = word_i;
    case (size_i)
      SZ_BYTE: begin
        load_o = unsigned_i ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        merged_o[{addr_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_HALF: begin
        load_o = unsigned_i ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
        merged_o[{addr_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      SZ_WORD: begin
        load_o   = word_i;
        merged_o = wdata_i;
      end
      default: begin
        load_o   = '0;
        merged_o = word_i;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module      : mem_access_unit
// Description : Initiator-side load/store unit. Accepts CPU requests over a
//               valid/ready handshake, issues aligned whole-word accesses,
//               performs read-modify-write for sub-word stores and flags
//               misaligned or illegal requests without touching memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = WORD_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              misalign_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              unsigned_q, unsigned_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              misalign_q, misalign_d;

  logic [DATA_W-1:0] align_word;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] merged_val;

  // Loads extract straight from the live read data; stores merge into the
  // word captured during the read phase.
  assign align_word = (state_q == ST_RD) ? mem_rdata_i : word_q;

  mem_lane_align u_lane_align (
    .word_i     (align_word),
    .addr_i     (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (unsigned_q),
    .wdata_i    (wdata_q),
    .load_o     (load_val),
    .merged_o   (merged_val)
  );

  // Strobes are gated with reset so an aborted transaction never writes.
  assign req_ready_o  = (state_q == ST_IDLE);
  assign resp_valid_o = (state_q == ST_RESP) && rst_i;
  assign mem_read_o   = (state_q == ST_RD) && rst_i;
  assign mem_write_o  = (state_q == ST_WR) && rst_i;
  assign mem_wdata_o  = mem_write_o ? merged_val : '0;
  assign mem_addr_o   = {addr_q[ADDR_W-1:2], 2'b00};
  assign resp_rdata_o = rdata_q;
  assign misalign_o   = misalign_q;

  // Next-state and datapath-capture logic.
  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    word_d     = word_q;
    rdata_d    = rdata_q;
    misalign_d = misalign_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          write_d    = req_write_i;
          size_d     = req_size_i;
          unsigned_d = req_unsigned_i;
          addr_d     = req_addr_i;
          wdata_d    = req_wdata_i;
          if (is_misaligned(req_size_i, req_addr_i[1:0])) begin
            state_d = ST_ERR;
          end else if (req_write_i && (req_size_i == SZ_WORD)) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        word_d = mem_rdata_i;
        if (write_q) begin
          state_d = ST_WR;
        end else begin
          rdata_d    = load_val;
          misalign_d = 1'b0;
          state_d    = ST_RESP;
        end
      end
      ST_WR: begin
        rdata_d    = '0;
        misalign_d = 1'b0;
        state_d    = ST_RESP;
      end
      ST_ERR: begin
        rdata_d    = '0;
        misalign_d = 1'b1;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      write_q    <= 1'b0;
      size_q     <= SZ_BYTE;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      word_q     <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      word_q     <= word_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Scoreboard bench for mem_access_unit with a small word
//               memory model and directed load/store/error/reset vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        misalign_o;
  logic [31:0] mem_addr_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_write_i    (req_write_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .resp_valid_o   (resp_valid_o),
    .resp_rdata_o   (resp_rdata_o),
    .misalign_o     (misalign_o),
    .mem_addr_o     (mem_addr_o),
    .mem_read_o     (mem_read_o),
    .mem_write_o    (mem_write_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rdata_i    (mem_rdata_i)
  );

  // Word memory: combinational read, write on the clock edge.
  logic [31:0] mem [0:15];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;

  assign mem_rdata_i = mem[mem_addr_o[5:2]];

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (mem_write_o) mem[mem_addr_o[5:2]] <= mem_wdata_o;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  int   resp_cnt = 0;
  int   issued   = 0;

  // Response monitor: pops the scoreboard on every completion pulse.
  always @(negedge clk) begin
    if (resp_valid_o) begin
      resp_cnt++;
      if (sbq.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("resp_rdata", resp_rdata_o, e.rdata);
        chk("resp_misalign", {31'd0, misalign_o}, {31'd0, e.mis});
        chk("resp_latency", cyc - e.acc, e.lat);
      end
    end
  end

  // Memory-side strobe logger and idle write-data check.
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] last_wa = '0;
  logic [31:0] last_wd = '0;
  always @(negedge clk) begin
    if (mem_write_o) begin
      wr_cnt++;
      last_wa = mem_addr_o;
      last_wd = mem_wdata_o;
    end else if (rst_i) begin
      chk("idle_wdata_zero", mem_wdata_o, 32'h0);
    end
    if (mem_read_o) rd_cnt++;
  end

  task automatic preload(input logic [3:0] idx, input logic [31:0] data);
    pl_idx  = idx;
    pl_data = data;
    pl_en   = 1'b1;
    @(negedge clk);
    pl_en   = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!req_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  // Drives one request, records its expected response when it is accepted.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_mis,
                        input int lat, input logic hold, output int waits);
    int n = 0;
    req_valid_i    = 1'b1;
    req_write_i    = wr;
    req_size_i     = sz;
    req_unsigned_i = uns;
    req_addr_i     = addr;
    req_wdata_i    = wdata;
    while (!req_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    waits = n;
    if (n >= 50) begin
      chk("accept_timeout", 32'd1, 32'd0);
      req_valid_i = 1'b0;
      return;
    end
    sbq.push_back('{exp_rdata, exp_mis, lat, cyc});
    issued++;
    @(negedge clk);
    if (!hold) req_valid_i = 1'b0;
  endtask

  // Single request followed by a wait for completion.
  task automatic op(input logic wr, input logic [1:0] sz, input logic uns,
                    input logic [31:0] addr, input logic [31:0] wdata,
                    input logic [31:0] exp_rdata, input logic exp_mis, input int lat);
    int w;
    do_req(wr, sz, uns, addr, wdata, exp_rdata, exp_mis, lat, 1'b0, w);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, wr0, w;
    rst_i = 1'b0;
    req_valid_i = 1'b0;
    req_write_i = 1'b0;
    req_size_i = 2'b00;
    req_unsigned_i = 1'b0;
    req_addr_i = '0;
    req_wdata_i = '0;
    for (int i = 0; i < 16; i++) preload(i[3:0], 32'h0);
    repeat (3) @(negedge clk);
    rst_i = 1'b1;

    // Reset state
    chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid_o}, 32'd0);
    chk("rst_rdata", resp_rdata_o, 32'h0);
    chk("rst_misalign", {31'd0, misalign_o}, 32'd0);
    chk("rst_strobes", {30'd0, mem_read_o, mem_write_o}, 32'd0);

    // Word store then word load
    rd0 = rd_cnt; wr0 = wr_cnt;
    op(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    chk("sw_write_pulses", wr_cnt - wr0, 1);
    chk("sw_read_pulses", rd_cnt - rd0, 0);
    chk("sw_waddr", last_wa, 32'h08);
    chk("sw_wdata", last_wd, 32'hDEADBEEF);
    op(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 32'hDEADBEEF, 1'b0, 2);

    // Byte and half read-modify-write stores
    preload(4'd1, 32'h11223344);
    rd0 = rd_cnt; wr0 = wr_cnt;
    op(1'b1, 2'b00, 1'b0, 32'h06, 32'h123456AA, 32'h0, 1'b0, 3);
    chk("sb_read_pulses", rd_cnt - rd0, 1);
    chk("sb_write_pulses", wr_cnt - wr0, 1);
    chk("sb_waddr", last_wa, 32'h04);
    chk("sb_wdata", last_wd, 32'h11AA3344);
    op(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'h11AA3344, 1'b0, 2);
    op(1'b1, 2'b01, 1'b0, 32'h06, 32'hCAFEBEEF, 32'h0, 1'b0, 3);
    chk("sh_wdata", last_wd, 32'hBEEF3344);
    op(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'hBEEF3344, 1'b0, 2);

    // Load extraction and extension
    preload(4'd3, 32'h80FF7F01);
    op(1'b0, 2'b00, 1'b0, 32'h0D, 32'h0, 32'h0000007F, 1'b0, 2);
    op(1'b0, 2'b00, 1'b0, 32'h0F, 32'h0, 32'hFFFFFF80, 1'b0, 2);
    op(1'b0, 2'b00, 1'b1, 32'h0E, 32'h0, 32'h000000FF, 1'b0, 2);
    op(1'b0, 2'b01, 1'b0, 32'h0E, 32'h0, 32'hFFFF80FF, 1'b0, 2);
    op(1'b0, 2'b01, 1'b1, 32'h0C, 32'h0, 32'h00007F01, 1'b0, 2);
    op(1'b0, 2'b10, 1'b1, 32'h0C, 32'h0, 32'h80FF7F01, 1'b0, 2);

    // Misaligned and illegal requests touch nothing
    preload(4'd0, 32'hCAFEF00D);
    preload(4'd2, 32'h0BADC0DE);
    rd0 = rd_cnt; wr0 = wr_cnt;
    op(1'b0, 2'b10, 1'b0, 32'h0A, 32'h0, 32'h0, 1'b1, 2);
    op(1'b1, 2'b01, 1'b0, 32'h03, 32'h0000FFFF, 32'h0, 1'b1, 2);
    op(1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 32'h0, 1'b1, 2);
    chk("err_read_pulses", rd_cnt - rd0, 0);
    chk("err_write_pulses", wr_cnt - wr0, 0);
    chk("err_mem0", mem[0], 32'hCAFEF00D);
    chk("err_mem2", mem[2], 32'h0BADC0DE);

    // Back-to-back with valid held high
    do_req(1'b0, 2'b00, 1'b0, 32'h00, 32'h0, 32'h0000000D, 1'b0, 2, 1'b1, w);
    chk("b2b_first_waits", w, 0);
    do_req(1'b1, 2'b10, 1'b0, 32'h04, 32'h01020304, 32'h0, 1'b0, 2, 1'b0, w);
    chk("b2b_second_waits", w, 2);
    wait_idle();
    op(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'h01020304, 1'b0, 2);
    repeat (3) @(negedge clk);
    chk("rdata_held", resp_rdata_o, 32'h01020304);

    // Reset during the write phase of a byte store
    preload(4'd4, 32'h55667788);
    wr0 = wr_cnt;
    req_valid_i = 1'b1; req_write_i = 1'b1; req_size_i = 2'b00;
    req_unsigned_i = 1'b0; req_addr_i = 32'h11; req_wdata_i = 32'h99;
    chk("rstwr_ready", {31'd0, req_ready_o}, 32'd1);
    @(negedge clk);
    req_valid_i = 1'b0;
    chk("rstwr_read_phase", {31'd0, mem_read_o}, 32'd1);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk("rstwr_write_gated", {31'd0, mem_write_o}, 32'd0);
    @(negedge clk);
    rst_i = 1'b1;
    chk("rstwr_ready_after", {31'd0, req_ready_o}, 32'd1);
    chk("rstwr_mem", mem[4], 32'h55667788);
    chk("rstwr_write_pulses", wr_cnt - wr0, 0);
    repeat (4) @(negedge clk);

    chk("scoreboard_empty", sbq.size(), 0);
    chk("resp_count", resp_cnt, issued);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
